acond_botones_cr: RTL

- Push-button conditioner that sits directly upstream of the chronometer/timer programming block and drives its 4-bit button input (IN_bot_cr).
- Takes the four raw, bouncing, asynchronous buttons from the board.
- Produces clean, one-hot, single-cycle command pulses in the reloj domain.
- Optional auto-repeat while a button is held, for fast scrolling of hour/min/sec fields.

---
 rtl/acond_botones_cr.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/acond_botones_cr.sv
`default_nettype none
// ============================================================================
//  Module   : acond_botones_cr
//  Purpose  : Push-button conditioner for the chronometer/timer programming
//             block. Synchronises and debounces four raw buttons and emits
//             clean one-hot, single-cycle press pulses in the reloj domain.
//  Ports    : reloj       - system clock, all state on the rising edge
//             resetM      - asynchronous reset, active-high
//             btn_raw     - raw buttons [3]=up [2]=down [1]=left [0]=right
//             habilitar   - 1 = pulses allowed, 0 = pulses suppressed
//             IN_bot_cr   - one-hot command pulse, one cycle wide
//             bot_estable - debounced level of each button
//             ocupado     - high while any debounced button is held
//  Options  : AUTO_REPEAT_EN - when defined, a button held alone repeats its
//             pulse after RETARDO_REP cycles, then every PERIODO_REP cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module acond_botones_cr #(
    parameter int CICLOS_REBOTE = 20,
    parameter int ANCHO_CNT     = 20,
    parameter int RETARDO_REP   = 50,
    parameter int PERIODO_REP   = 10
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic [3:0] btn_raw,
    input  logic       habilitar,
    output logic [3:0] IN_bot_cr,
    output logic [3:0] bot_estable,
    output logic       ocupado
);

    localparam logic [ANCHO_CNT-1:0] C_REB_MAX = ANCHO_CNT'(CICLOS_REBOTE - 1);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] estable_q;
    logic [3:0] estable_d;
    logic [3:0] estable_prev_q;
    logic       ocupado_q;
    logic [3:0] pulso_q;
    logic [3:0] pulso_d;
    logic [3:0] eventos;
    logic       cambio;
    logic [3:0] ganador;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: a channel only flips once the synchronised level
    // has disagreed with the stable level for CICLOS_REBOTE consecutive cycles.
    for (genvar i = 0; i < 4; i++) begin : g_canal
        logic [ANCHO_CNT-1:0] cnt_q;
        logic [ANCHO_CNT-1:0] cnt_d;
        logic                 est_d;

        always_comb begin
            cnt_d = '0;
            est_d = estable_q[i];
            if (sync2_q[i] != estable_q[i]) begin
                if (cnt_q >= C_REB_MAX) begin
                    est_d = ~estable_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge reloj or posedge resetM) begin
            if (resetM) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign estable_d[i] = est_d;
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            estable_q      <= 4'b0000;
            estable_prev_q <= 4'b0000;
            ocupado_q      <= 1'b0;
            pulso_q        <= 4'b0000;
        end else begin
            estable_q      <= estable_d;
            estable_prev_q <= estable_q;
            ocupado_q      <= |estable_d;
            pulso_q        <= pulso_d;
        end
    end

    // Press events are rising edges of the debounced level; releases are ignored.
    assign eventos = estable_q & ~estable_prev_q;
    assign cambio  = (estable_q != estable_prev_q);

    // Fixed priority up > down > left > right; losing events are dropped.
    always_comb begin
        ganador = 4'b0000;
        if (eventos[3]) begin
            ganador = 4'b1000;
        end else if (eventos[2]) begin
            ganador = 4'b0100;
        end else if (eventos[1]) begin
            ganador = 4'b0010;
        end else if (eventos[0]) begin
            ganador = 4'b0001;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [ANCHO_CNT-1:0] C_RET_MAX = ANCHO_CNT'(RETARDO_REP - 1);
    localparam logic [ANCHO_CNT-1:0] C_PER_MAX = ANCHO_CNT'(PERIODO_REP - 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ESPERA = 2'd1,
        REPITE = 2'd2
    } estado_t;

    estado_t              estado_q;
    estado_t              estado_d;
    logic [ANCHO_CNT-1:0] rep_cnt_q;
    logic [ANCHO_CNT-1:0] rep_cnt_d;
    logic [3:0]           rep_btn_q;
    logic [3:0]           rep_btn_d;

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            estado_q  <= REPOSO;
            rep_cnt_q <= '0;
            rep_btn_q <= 4'b0000;
        end else begin
            estado_q  <= estado_d;
            rep_cnt_q <= rep_cnt_d;
            rep_btn_q <= rep_btn_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        rep_cnt_d = rep_cnt_q;
        rep_btn_d = rep_btn_q;
        pulso_d   = 4'b0000;
        case (estado_q)
            REPOSO: begin
                // The winning button is remembered so that a second, still
                // held, losing button cannot steal the repeat pulses.
                if (habilitar && (ganador != 4'b0000)) begin
                    pulso_d   = ganador;
                    estado_d  = ESPERA;
                    rep_cnt_d = '0;
                    rep_btn_d = ganador;
                end
            end
            ESPERA: begin
                if (cambio) begin
                    estado_d  = REPOSO;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q >= C_RET_MAX) begin
                    estado_d  = REPITE;
                    rep_cnt_d = '0;
                    if (habilitar) begin
                        pulso_d = rep_btn_q;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            REPITE: begin
                if (cambio) begin
                    estado_d  = REPOSO;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q >= C_PER_MAX) begin
                    rep_cnt_d = '0;
                    if (habilitar) begin
                        pulso_d = rep_btn_q;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d  = REPOSO;
                rep_cnt_d = '0;
            end
        endcase
    end
`else
    // Without auto-repeat every accepted press yields exactly one pulse.
    always_comb begin
        pulso_d = 4'b0000;
        if (habilitar) begin
            pulso_d = ganador;
        end
    end

    // Repeat timing has no effect in this build; the parameters are kept so
    // both builds share one interface.
    if ((RETARDO_REP < 1) || (PERIODO_REP < 1)) begin : g_rep_sin_uso
    end
`endif

    assign IN_bot_cr   = pulso_q;
    assign bot_estable = estable_q;
    assign ocupado     = ocupado_q;

endmodule
`default_nettype wire
